uart_txrx: RTL and testbench

UART_TXRX -- requirements
Module: uart_txrx

---
 rtl/uart_txrx.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_txrx.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txrx.sv
// uart_txrx: independent UART transmitter and receiver sharing one oversampling
// tick. Frames are start + DBIT data (LSB first) + stop. Defining UART_PARITY_EN
// inserts an even-parity bit before the stop bit in both directions.
// rx is sampled directly; it must already be synchronous to clk.
module uart_txrx #(
  parameter int DBIT    = 8,
  parameter int S_TICK  = 16,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_din,
  output logic            tx_done_tick,
  output logic            tx,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done,
  output logic            rx_frame_error
);

  localparam int TMAX = (S_TICK > SB_TICK) ? S_TICK : SB_TICK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] S_LAST  = TW'(S_TICK - 1);
  localparam logic [TW-1:0] S_HALF  = TW'(S_TICK / 2 - 1);
  localparam logic [TW-1:0] SB_LAST = TW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          tx_state_reg, tx_state_next;
  logic [TW-1:0]   tx_s_reg, tx_s_next;
  logic [NW-1:0]   tx_n_reg, tx_n_next;
  logic [DBIT-1:0] tx_b_reg, tx_b_next;
  logic            tx_reg, tx_next;
  logic            tx_done_reg, tx_done_next;
  logic            tx_par_reg, tx_par_next;

  state_t          rx_state_reg, rx_state_next;
  logic [TW-1:0]   rx_s_reg, rx_s_next;
  logic [NW-1:0]   rx_n_reg, rx_n_next;
  logic [DBIT-1:0] rx_b_reg, rx_b_next;
  logic [DBIT-1:0] rx_data_reg, rx_data_next;
  logic            rx_ferr_reg, rx_ferr_next;
  logic            rx_done_reg, rx_done_next;
  logic            rx_perr_reg, rx_perr_next;

  // TX and RX state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_reg <= IDLE;
      tx_s_reg     <= '0;
      tx_n_reg     <= '0;
      tx_b_reg     <= '0;
      tx_reg       <= 1'b1;
      tx_done_reg  <= 1'b0;
      tx_par_reg   <= 1'b0;
      rx_state_reg <= IDLE;
      rx_s_reg     <= '0;
      rx_n_reg     <= '0;
      rx_b_reg     <= '0;
      rx_data_reg  <= '0;
      rx_ferr_reg  <= 1'b0;
      rx_done_reg  <= 1'b0;
      rx_perr_reg  <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_s_reg     <= tx_s_next;
      tx_n_reg     <= tx_n_next;
      tx_b_reg     <= tx_b_next;
      tx_reg       <= tx_next;
      tx_done_reg  <= tx_done_next;
      tx_par_reg   <= tx_par_next;
      rx_state_reg <= rx_state_next;
      rx_s_reg     <= rx_s_next;
      rx_n_reg     <= rx_n_next;
      rx_b_reg     <= rx_b_next;
      rx_data_reg  <= rx_data_next;
      rx_ferr_reg  <= rx_ferr_next;
      rx_done_reg  <= rx_done_next;
      rx_perr_reg  <= rx_perr_next;
    end
  end

  // TX next-state: frame sequencing, bit shifting and done pulse
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_s_next     = tx_s_reg;
    tx_n_next     = tx_n_reg;
    tx_b_next     = tx_b_reg;
    tx_par_next   = tx_par_reg;
    tx_done_next  = 1'b0;
    case (tx_state_reg)
      IDLE: begin
        if (tx_start) begin
          tx_state_next = START;
          tx_s_next     = '0;
          tx_b_next     = tx_din;
          tx_par_next   = ^tx_din;
        end
      end
      START: begin
        if (s_tick) begin
          if (tx_s_reg == S_LAST) begin
            tx_state_next = DATA;
            tx_s_next     = '0;
            tx_n_next     = '0;
          end else begin
            tx_s_next = tx_s_reg + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tx_s_reg == S_LAST) begin
            tx_s_next = '0;
            tx_b_next = tx_b_reg >> 1;
            if (tx_n_reg == N_LAST) begin
`ifdef UART_PARITY_EN
              tx_state_next = PARITY;
`else
              tx_state_next = STOP;
`endif
            end else begin
              tx_n_next = tx_n_reg + NW'(1);
            end
          end else begin
            tx_s_next = tx_s_reg + TW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (tx_s_reg == S_LAST) begin
            tx_state_next = STOP;
            tx_s_next     = '0;
          end else begin
            tx_s_next = tx_s_reg + TW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (tx_s_reg == SB_LAST) begin
            tx_state_next = IDLE;
            tx_done_next  = 1'b1;
          end else begin
            tx_s_next = tx_s_reg + TW'(1);
          end
        end
      end
      default: tx_state_next = IDLE;
    endcase
  end

  // TX line level follows the upcoming state so tx stays aligned with it
  always_comb begin
    tx_next = 1'b1;
    case (tx_state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = tx_b_next[0];
      PARITY:  tx_next = tx_par_next;
      default: tx_next = 1'b1;
    endcase
  end

  // RX next-state: start validation, mid-bit sampling and frame completion
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_s_next     = rx_s_reg;
    rx_n_next     = rx_n_reg;
    rx_b_next     = rx_b_reg;
    rx_data_next  = rx_data_reg;
    rx_ferr_next  = rx_ferr_reg;
    rx_perr_next  = rx_perr_reg;
    rx_done_next  = 1'b0;
    case (rx_state_reg)
      IDLE: begin
        if (!rx) begin
          rx_state_next = START;
          rx_s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (rx_s_reg == S_HALF) begin
            rx_s_next = '0;
            rx_n_next = '0;
            rx_state_next = rx ? IDLE : DATA;
          end else begin
            rx_s_next = rx_s_reg + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (rx_s_reg == S_LAST) begin
            rx_s_next = '0;
            rx_b_next = {rx, rx_b_reg[DBIT-1:1]};
            if (rx_n_reg == N_LAST) begin
`ifdef UART_PARITY_EN
              rx_state_next = PARITY;
`else
              rx_state_next = STOP;
`endif
            end else begin
              rx_n_next = rx_n_reg + NW'(1);
            end
          end else begin
            rx_s_next = rx_s_reg + TW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (rx_s_reg == S_LAST) begin
            rx_state_next = STOP;
            rx_s_next     = '0;
            rx_perr_next  = rx ^ (^rx_b_reg);
          end else begin
            rx_s_next = rx_s_reg + TW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (rx_s_reg == SB_LAST) begin
            rx_state_next = IDLE;
            rx_s_next     = '0;
            rx_done_next  = 1'b1;
            rx_data_next  = rx_b_reg;
`ifdef UART_PARITY_EN
            rx_ferr_next  = ~rx | rx_perr_reg;
`else
            rx_ferr_next  = ~rx;
`endif
          end else begin
            rx_s_next = rx_s_reg + TW'(1);
          end
        end
      end
      default: rx_state_next = IDLE;
    endcase
  end

  assign tx             = tx_reg;
  assign tx_done_tick   = tx_done_reg;
  assign rx_data        = rx_data_reg;
  assign rx_done        = rx_done_reg;
  assign rx_frame_error = rx_ferr_reg;

endmodule

// File: tb/tb_uart_txrx.sv
// tb_uart_txrx: directed + randomized checks of uart_txrx against a frame-level
// model (bit list with durations in ticks). Parity-aware when UART_PARITY_EN is set.
module tb_uart_txrx;

  localparam int DBIT    = 8;
  localparam int S_TICK  = 16;
  localparam int SB_TICK = 16;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 1 + DBIT + PAR + 1;

  logic            clk;
  logic            reset;
  logic            s_tick;
  logic            tx_start;
  logic [DBIT-1:0] tx_din;
  logic            tx_done_tick;
  logic            tx;
  logic            rx_line;
  logic [DBIT-1:0] rx_data;
  logic            rx_done;
  logic            rx_frame_error;

  logic loop_en;
  logic rx_drv;
  logic tick_rand;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int rx_done_cnt  = 0;
  int tx_done_cnt  = 0;
  int hold_viol    = 0;
  int last_rx_cyc  = 0;
  int start_cyc    = 0;
  logic [DBIT-1:0] last_data;
  logic            last_ferr;
  logic [DBIT-1:0] held_data;
  logic            held_ferr;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_txrx #(.DBIT(DBIT), .S_TICK(S_TICK), .SB_TICK(SB_TICK)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_tick         (s_tick),
    .tx_start       (tx_start),
    .tx_din         (tx_din),
    .tx_done_tick   (tx_done_tick),
    .tx             (tx),
    .rx             (rx_line),
    .rx_data        (rx_data),
    .rx_done        (rx_done),
    .rx_frame_error (rx_frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and rx output hold check, sampled shortly after each edge
  always @(posedge clk) begin
    #2;
    cyc++;
    if (rx_done === 1'b1) begin
      rx_done_cnt++;
      last_data   = rx_data;
      last_ferr   = rx_frame_error;
      last_rx_cyc = cyc;
    end
    if (tx_done_tick === 1'b1) tx_done_cnt++;
    if (reset || rx_done === 1'b1) begin
      held_data = rx_data;
      held_ferr = rx_frame_error;
    end else if (rx_data !== held_data || rx_frame_error !== held_ferr) begin
      hold_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (tick_rand) s_tick = 1'($urandom_range(0, 1));
  endtask

  // Line level of frame bit idx: start, data LSB first, optional even parity, stop
  function automatic logic bit_level(input logic [DBIT-1:0] d, input int idx, input logic par_good);
    if (idx == 0) return 1'b0;
    if (idx <= DBIT) return d[idx-1];
    if (PAR == 1 && idx == DBIT + 1) return 1'(($countones(d) % 2) == 1) ^ ~par_good;
    return 1'b1;
  endfunction

  // Transmit d with s_tick=1 and check every tx cycle against the frame model;
  // optionally pulse tx_start with 0x11 at cycle inject_at of the frame
  task automatic send_tx(input logic [DBIT-1:0] d, input int inject_at, input string tag);
    int k;
    int bad;
    step();
    tx_start  = 1'b1;
    tx_din    = d;
    start_cyc = cyc;
    step();
    tx_start = 1'b0;
    tx_din   = 8'($urandom);
    k = 0;
    for (int b = 0; b < NBITS; b++) begin
      int len;
      len = (b == NBITS - 1) ? SB_TICK : S_TICK;
      bad = 0;
      for (int j = 0; j < len; j++) begin
        if (tx !== bit_level(d, b, 1'b1)) bad++;
        if (tx_done_tick !== 1'b0) bad++;
        if (k == inject_at) begin
          tx_start = 1'b1;
          tx_din   = 8'h11;
        end else begin
          tx_start = 1'b0;
        end
        step();
        k++;
      end
      check($sformatf("%s bit%0d", tag, b), bad, 0);
    end
    check({tag, " done"}, tx_done_tick, 1);
  endtask

  // Drive a frame onto rx directly with chosen stop level and parity correctness
  task automatic drive_rx(input logic [DBIT-1:0] d, input logic stop_lvl, input logic par_good);
    for (int b = 0; b < NBITS; b++) begin
      int len;
      len = (b == NBITS - 1) ? SB_TICK : S_TICK;
      for (int j = 0; j < len; j++) begin
        rx_drv = (b == NBITS - 1) ? stop_lvl : bit_level(d, b, par_good);
        step();
      end
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rx(input int prev, input int budget, input string tag);
    for (int i = 0; i < budget && rx_done_cnt <= prev; i++) step();
    check({tag, " rx_done seen"}, (rx_done_cnt > prev), 1);
  endtask

  task automatic wait_tx(input int prev, input int budget, input string tag);
    for (int i = 0; i < budget && tx_done_cnt <= prev; i++) step();
    check({tag, " tx_done seen"}, (tx_done_cnt > prev), 1);
  endtask

  initial begin
    int p_rx;
    int p_tx;
    logic [DBIT-1:0] d;
    logic stop_lvl;

    reset     = 1'b1;
    s_tick    = 1'b1;
    tick_rand = 1'b0;
    tx_start  = 1'b1;
    tx_din    = 8'hFF;
    loop_en   = 1'b1;
    rx_drv    = 1'b1;
    repeat (3) step();
    check("reset tx", tx, 1);
    check("reset tx_done", tx_done_tick, 0);
    check("reset rx_done", rx_done, 0);
    check("reset rx_data", rx_data, 0);
    check("reset ferr", rx_frame_error, 0);
    reset    = 1'b0;
    tx_start = 1'b0;
    repeat (20) step();
    check("start during reset ignored tx", tx, 1);
    check("start during reset no done", tx_done_cnt, 0);

    // Loopback 0xA5
    p_rx = rx_done_cnt; p_tx = tx_done_cnt;
    send_tx(8'hA5, -1, "lb A5");
    repeat (5) step();
    check("lb A5 rx_done count", rx_done_cnt - p_rx, 1);
    check("lb A5 tx_done count", tx_done_cnt - p_tx, 1);
    check("lb A5 rx_data", last_data, 8'hA5);
    check("lb A5 ferr", last_ferr, 0);
    check("lb A5 latency<=170", ((last_rx_cyc - start_cyc) <= 170), 1);
    check("rx_data holds A5", rx_data, 8'hA5);

    // Loopback 0x3C, rx_data must hold A5 until the new rx_done
    p_rx = rx_done_cnt;
    send_tx(8'h3C, -1, "lb 3C");
    repeat (5) step();
    check("lb 3C rx_done count", rx_done_cnt - p_rx, 1);
    check("lb 3C rx_data", last_data, 8'h3C);
    check("lb 3C ferr", last_ferr, 0);
    check("rx hold after 3C", hold_viol, 0);

    // tx_start with 0x11 mid-frame is ignored
    p_rx = rx_done_cnt; p_tx = tx_done_cnt;
    send_tx(8'hA5, 50, "inject");
    repeat (5) step();
    check("inject tx_done count", tx_done_cnt - p_tx, 1);
    check("inject rx_data", last_data, 8'hA5);
    repeat (40) step();
    check("inject no extra frame", tx_done_cnt - p_tx, 1);

    // Random loopback frames, s_tick=1, full waveform check
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      p_rx = rx_done_cnt;
      send_tx(d, -1, $sformatf("rand%0d", i));
      repeat (3) step();
      check($sformatf("rand%0d rx_data", i), last_data, d);
      check($sformatf("rand%0d ferr", i), last_ferr, 0);
    end

    // Random loopback frames with irregular s_tick
    tick_rand = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      p_rx = rx_done_cnt; p_tx = tx_done_cnt;
      step();
      tx_start = 1'b1;
      tx_din   = d;
      step();
      tx_start = 1'b0;
      wait_rx(p_rx, 2000, $sformatf("tick%0d", i));
      check($sformatf("tick%0d rx_data", i), last_data, d);
      check($sformatf("tick%0d ferr", i), last_ferr, 0);
      wait_tx(p_tx, 2000, $sformatf("tick%0d", i));
    end
    tick_rand = 1'b0;
    s_tick    = 1'b1;
    repeat (10) step();

    // Start-bit glitch, then a valid 0x55 frame
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (5) step();
    p_rx = rx_done_cnt;
    rx_drv = 1'b0;
    repeat (4) step();
    rx_drv = 1'b1;
    repeat (40) step();
    check("glitch no rx_done", rx_done_cnt - p_rx, 0);
    drive_rx(8'h55, 1'b1, 1'b1);
    wait_rx(p_rx, 50, "after glitch");
    check("after glitch rx_data", last_data, 8'h55);
    check("after glitch ferr", last_ferr, 0);
    repeat (20) step();

    // Bad stop bit on 0xF0
    p_rx = rx_done_cnt;
    drive_rx(8'hF0, 1'b0, 1'b1);
    wait_rx(p_rx, 50, "stop0");
    check("stop0 rx_data", last_data, 8'hF0);
    check("stop0 ferr", last_ferr, 1);
    repeat (30) step();
    check("stop0 single rx_done", rx_done_cnt - p_rx, 1);

    // Random driven frames with random stop level
    for (int i = 0; i < 4; i++) begin
      d        = 8'($urandom);
      stop_lvl = 1'($urandom_range(0, 1));
      p_rx = rx_done_cnt;
      drive_rx(d, stop_lvl, 1'b1);
      wait_rx(p_rx, 50, $sformatf("drv%0d", i));
      check($sformatf("drv%0d rx_data", i), last_data, d);
      check($sformatf("drv%0d ferr", i), last_ferr, {31'd0, ~stop_lvl});
      repeat (30) step();
    end

`ifdef UART_PARITY_EN
    // Parity: 0x07 has odd weight so the parity bit is 1; wrong parity flags an error
    loop_en = 1'b1;
    repeat (5) step();
    p_rx = rx_done_cnt;
    send_tx(8'h07, -1, "par 07");
    repeat (20) step();
    check("par 07 rx_data", last_data, 8'h07);
    check("par 07 ferr", last_ferr, 0);
    loop_en = 1'b0;
    repeat (5) step();
    p_rx = rx_done_cnt;
    drive_rx(8'h07, 1'b1, 1'b0);
    wait_rx(p_rx, 50, "bad par");
    check("bad par ferr", last_ferr, 1);
    repeat (30) step();
    p_rx = rx_done_cnt;
    drive_rx(8'h3A, 1'b1, 1'b1);
    wait_rx(p_rx, 50, "good par");
    check("good par ferr", last_ferr, 0);
    repeat (30) step();
`endif

    check("rx hold overall", hold_viol, 0);

    // Reset mid-frame aborts both directions with no done pulses
    loop_en = 1'b1;
    repeat (5) step();
    p_rx = rx_done_cnt; p_tx = tx_done_cnt;
    tx_start = 1'b1;
    tx_din   = 8'h5A;
    step();
    tx_start = 1'b0;
    repeat (60) step();
    reset = 1'b1;
    step();
    check("midreset tx", tx, 1);
    step();
    reset = 1'b0;
    repeat (250) step();
    check("midreset no tx_done", tx_done_cnt - p_tx, 0);
    check("midreset no rx_done", rx_done_cnt - p_rx, 0);
    check("midreset rx_data", rx_data, 0);
    check("midreset ferr", rx_frame_error, 0);
    check("midreset tx idle", tx, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
